gate_range_ctrl: RTL and testbench

Measurement sequencer and auto-ranging controller for the frequency meter. It drives the 2-bit reference select of the gate-frequency multiplexer and watches the selected reference (`Ctrl_CP`). From that reference it opens and closes the count gate, then latches and clears the BCD counter chain. After each measurement it moves to the next gate range when the count overflowed or was too small. It sits between the reference divider/mux and the counter/latch/display datapath.

---
 rtl/gate_range_ctrl.sv | 173 +++++++++++++++++
 tb/tb_gate_range_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_range_ctrl.sv
// Measurement sequencer and auto-ranging controller for the frequency meter.
// Opens a one-reference-period count gate, latches/clears the counter chain,
// and steps the gate reference select up on overflow or down on underrange.
//
// Ports:
//   CP, RST          : clock, synchronous active-high reset
//   Ctrl_CP          : selected gate reference (synchronous to CP)
//   Auto, F_manual   : auto-range enable, manual range
//   Over_Flow        : counter carry-out, sampled during the gate
//   Cnt_MSD_Zero     : top counter digit is zero, sampled in evaluation
//   F_sel            : reference mux select (00=1Hz .. 11=1kHz)
//   Cnt_EN, Cnt_CLR  : counter gate enable, one-cycle counter clear
//   Latch_EN         : one-cycle display latch load
//   Meas_Done        : one-cycle pulse with Latch_EN
//   Range_Err        : last measurement overflowed at the top range
//   Ref_Lost         : sticky reference timeout, cleared by next latch
`timescale 1ns/1ps
module gate_range_ctrl #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       CP,
  input  logic       RST,
  input  logic       Ctrl_CP,
  input  logic       Auto,
  input  logic [1:0] F_manual,
  input  logic       Over_Flow,
  input  logic       Cnt_MSD_Zero,
  output logic [1:0] F_sel,
  output logic       Cnt_EN,
  output logic       Cnt_CLR,
  output logic       Latch_EN,
  output logic       Meas_Done,
  output logic       Range_Err,
  output logic       Ref_Lost
);

  localparam int CMAX =
    (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CW = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_SETTLE,
    S_ARM,
    S_GATE,
    S_LATCH,
    S_EVAL
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ctrl_q;
  logic            r_ovf;
  logic [1:0]      r_fsel;
  logic            r_cnt_en;
  logic            r_cnt_clr;
  logic            r_latch;
  logic            r_rerr;
  logic            r_lost;

  state_t          w_nstate;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_ovf_nxt;
  logic [1:0]      w_fsel_nxt;
  logic            w_rerr_nxt;
  logic            w_lost_nxt;
  logic            w_rise;

  assign w_rise = Ctrl_CP & ~r_ctrl_q;

  always_comb begin
    w_nstate   = r_state;
    w_cnt_nxt  = r_cnt;
    w_ovf_nxt  = r_ovf;
    w_fsel_nxt = r_fsel;
    w_rerr_nxt = r_rerr;
    w_lost_nxt = r_lost;
    unique case (r_state)
      S_CLEAR: begin
        // Stay until the clear pulse has actually been driven;
        // this also yields the clear pulse right after reset.
        w_ovf_nxt = 1'b0;
        w_cnt_nxt = '0;
        if (r_cnt_clr) w_nstate = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == SET_LAST) begin
          w_cnt_nxt = '0;
          w_nstate  = S_ARM;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ARM: begin
        if (r_cnt == TO_LAST) begin
          w_lost_nxt = 1'b1;
          w_nstate   = S_CLEAR;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_rise) w_nstate = S_GATE;
        end
      end
      S_GATE: begin
        w_ovf_nxt = r_ovf | Over_Flow;
        if (r_cnt == TO_LAST) begin
          w_lost_nxt = 1'b1;
          w_nstate   = S_CLEAR;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_rise) begin
            w_lost_nxt = 1'b0;
            w_nstate   = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        w_nstate = S_EVAL;
      end
      S_EVAL: begin
        w_nstate   = S_CLEAR;
        w_rerr_nxt = r_ovf & (r_fsel == 2'b11);
        if (!Auto) begin
          w_fsel_nxt = F_manual;
        end else if (r_ovf) begin
          if (r_fsel != 2'b11) w_fsel_nxt = r_fsel + 1'b1;
        end else if (Cnt_MSD_Zero && (r_fsel != 2'b00)) begin
          w_fsel_nxt = r_fsel - 1'b1;
        end
      end
      default: begin
        w_nstate = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      r_state   <= S_CLEAR;
      r_cnt     <= '0;
      r_ctrl_q  <= 1'b0;
      r_ovf     <= 1'b0;
      r_fsel    <= Auto ? 2'b00 : F_manual;
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_latch   <= 1'b0;
      r_rerr    <= 1'b0;
      r_lost    <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_cnt     <= w_cnt_nxt;
      r_ctrl_q  <= Ctrl_CP;
      r_ovf     <= w_ovf_nxt;
      r_fsel    <= w_fsel_nxt;
      r_cnt_en  <= (w_nstate == S_GATE);
      r_cnt_clr <= (w_nstate == S_CLEAR);
      r_latch   <= (w_nstate == S_LATCH);
      r_rerr    <= w_rerr_nxt;
      r_lost    <= w_lost_nxt;
    end
  end

  assign F_sel     = r_fsel;
  assign Cnt_EN    = r_cnt_en;
  assign Cnt_CLR   = r_cnt_clr;
  assign Latch_EN  = r_latch;
  assign Meas_Done = r_latch;
  assign Range_Err = r_rerr;
  assign Ref_Lost  = r_lost;

endmodule

// File: tb/tb_gate_range_ctrl.sv
// Directed bench for gate_range_ctrl.
// Reference period 20 CP, settle 4, timeout 50.
`timescale 1ns/1ps
module tb_gate_range_ctrl;

  logic       CP;
  logic       RST;
  logic       Ctrl_CP;
  logic       Auto;
  logic [1:0] F_manual;
  logic       Over_Flow;
  logic       Cnt_MSD_Zero;
  logic [1:0] F_sel;
  logic       Cnt_EN;
  logic       Cnt_CLR;
  logic       Latch_EN;
  logic       Meas_Done;
  logic       Range_Err;
  logic       Ref_Lost;

  int  n_chk  = 0;
  int  n_pass = 0;
  int  cyc    = 0;
  bit  ref_on = 1'b1;

  gate_range_ctrl #(
    .SETTLE_CYC (4),
    .TIMEOUT_CYC(50)
  ) dut (
    .CP          (CP),
    .RST         (RST),
    .Ctrl_CP     (Ctrl_CP),
    .Auto        (Auto),
    .F_manual    (F_manual),
    .Over_Flow   (Over_Flow),
    .Cnt_MSD_Zero(Cnt_MSD_Zero),
    .F_sel       (F_sel),
    .Cnt_EN      (Cnt_EN),
    .Cnt_CLR     (Cnt_CLR),
    .Latch_EN    (Latch_EN),
    .Meas_Done   (Meas_Done),
    .Range_Err   (Range_Err),
    .Ref_Lost    (Ref_Lost)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  // Reference: 10 CP high, 10 CP low, gated by ref_on.
  initial begin
    Ctrl_CP = 1'b0;
    forever begin
      @(posedge CP);
      #1;
      cyc++;
      Ctrl_CP = ref_on && ((cyc % 20) < 10);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Runs from a CLEAR cycle to the next CLEAR cycle.
  task automatic measure(input string tag,
                         input logic [1:0] exp_fsel,
                         input int exp_rerr,
                         input int exp_en);
    int         en;
    bit         got;
    logic [1:0] f0;
    en  = 0;
    got = 1'b0;
    f0  = F_sel;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge CP);
      en += int'(Cnt_EN);
      if (Latch_EN) got = 1'b1;
    end
    check({tag, "_latch_seen"}, got, 1);
    if (got) begin
      check({tag, "_meas_done"}, Meas_Done, 1);
      check({tag, "_fsel_hold"}, F_sel, f0);
      check({tag, "_reflost"}, Ref_Lost, 0);
      if (exp_en >= 0) check({tag, "_en_cycles"}, en, exp_en);
      @(negedge CP);
      check({tag, "_latch_1cyc"}, Latch_EN, 0);
      @(negedge CP);
      check({tag, "_clr"}, Cnt_CLR, 1);
      check({tag, "_fsel"}, F_sel, exp_fsel);
      if (exp_rerr >= 0) check({tag, "_rerr"}, Range_Err, exp_rerr);
    end
  endtask

  task automatic wait_gate(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CP);
      if (Cnt_EN) seen = 1'b1;
    end
    check({tag, "_gate_seen"}, seen, 1);
  endtask

  task automatic count_to_clr(input string tag, input int exp_n);
    int n;
    n = 0;
    for (int i = 1; i <= 200 && n == 0; i++) begin
      @(negedge CP);
      if (Cnt_CLR) n = i;
    end
    check({tag, "_cycles"}, n, exp_n);
    check({tag, "_reflost"}, Ref_Lost, 1);
    check({tag, "_en"}, Cnt_EN, 0);
  endtask

  initial begin
    RST          = 1'b1;
    Auto         = 1'b1;
    F_manual     = 2'b00;
    Over_Flow    = 1'b0;
    Cnt_MSD_Zero = 1'b0;
    repeat (3) @(negedge CP);
    check("rst_fsel", F_sel, 0);
    check("rst_en", Cnt_EN, 0);
    check("rst_clr", Cnt_CLR, 0);
    check("rst_latch", Latch_EN, 0);
    check("rst_done", Meas_Done, 0);
    check("rst_rerr", Range_Err, 0);
    check("rst_lost", Ref_Lost, 0);
    RST = 1'b0;
    @(negedge CP);
    check("rst_first_clr", Cnt_CLR, 1);

    measure("nom0", 2'd0, 0, 20);
    measure("nom1", 2'd0, 0, 20);

    Over_Flow = 1'b1;
    measure("ovf1", 2'd1, 0, 20);
    measure("ovf2", 2'd2, 0, 20);
    measure("ovf3", 2'd3, 0, 20);
    measure("ovf4", 2'd3, 1, 20);
    Over_Flow = 1'b0;
    measure("ovf_off", 2'd3, 0, 20);

    Cnt_MSD_Zero = 1'b1;
    measure("dn1", 2'd2, 0, 20);
    measure("dn2", 2'd1, 0, 20);
    measure("dn3", 2'd0, 0, 20);
    measure("dn4", 2'd0, 0, 20);
    Cnt_MSD_Zero = 1'b0;
    Over_Flow    = 1'b1;
    measure("up01", 2'd1, 0, 20);
    Cnt_MSD_Zero = 1'b1;
    measure("prio", 2'd2, 0, 20);
    Cnt_MSD_Zero = 1'b0;
    Over_Flow    = 1'b0;

    Auto     = 1'b0;
    F_manual = 2'b01;
    measure("man1", 2'd1, 0, 20);
    Over_Flow = 1'b1;
    wait_gate("man_mid");
    repeat (3) @(negedge CP);
    F_manual = 2'b10;
    check("man_mid_fsel", F_sel, 1);
    measure("man2", 2'd2, -1, -1);
    measure("man3", 2'd2, -1, 20);

    Auto      = 1'b1;
    Over_Flow = 1'b0;
    ref_on    = 1'b0;
    count_to_clr("to1", 55);
    count_to_clr("to2", 55);
    check("to_fsel", F_sel, 2);
    ref_on = 1'b1;
    measure("restore", 2'd2, 0, 20);

    wait_gate("rst_mid");
    RST = 1'b1;
    @(negedge CP);
    check("rstg_en", Cnt_EN, 0);
    check("rstg_fsel", F_sel, 0);
    RST = 1'b0;
    @(negedge CP);
    check("rstg_clr", Cnt_CLR, 1);
    measure("post_rst", 2'd0, 0, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
